// File: rtl/ca_code_ctrl.sv
// ca_code_ctrl -- run/sequence controller for the GPS C/A code generator.
//
// Turns the board buttons into a PRN selection and run/stop control. It
// derives the 1.023 MHz chip strobe from clk with a fractional phase
// accumulator. It tracks the chip index inside the 1023-chip epoch and
// pulses gen_load whenever the G1/G2 registers must restart.
//
// Optional feature: define CA_EXT_SYNC_EN to synchronize ext_sync (BNC2).
// Its rising edge then re-aligns the epoch through RESYNC -> LOAD.
// Without the macro, ext_sync is ignored and RESYNC is unreachable.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   btn_up/btn_down/btn_run   raw asynchronous buttons, active-high
//   ext_sync                  raw asynchronous external sync input
//   prn_sel[5:0]              PRN applied to the generator taps (1..32)
//   gen_load                  one-cycle reload pulse for G1/G2
//   chip_en                   one-cycle chip advance strobe
//   chip_idx[9:0]             index of the chip currently presented
//   epoch                     strobe that wraps chip_idx from 1022 to 0
//   running                   high in RUN
//   led[9:0]                  {epoch toggle, running, state, prn_sel}
module ca_code_ctrl #(
    parameter int CLK_HZ       = 12000000,
    parameter int CHIP_HZ      = 1023000,
    parameter int ACC_W        = 24,
    parameter int DEBOUNCE_CYC = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_run,
    input  logic       ext_sync,
    output logic [5:0] prn_sel,
    output logic       gen_load,
    output logic       chip_en,
    output logic [9:0] chip_idx,
    output logic       epoch,
    output logic       running,
    output logic [9:0] led
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESYNC = 2'd3
    } state_t;

    // Phase increment, rounded to nearest: CHIP_HZ * 2^ACC_W / CLK_HZ.
    localparam logic [63:0] INC_WIDE =
        ((64'(CHIP_HZ) << ACC_W) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
    localparam logic [ACC_W-1:0] INC      = INC_WIDE[ACC_W-1:0];
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [9:0]       IDX_LAST = 10'd1022;

    // ---------------- button conditioning ----------------
    // Bit order everywhere: [0]=up, [1]=down, [2]=run.
    logic [2:0]       btn_raw_s;
    logic [2:0]       btn_meta_r;
    logic [2:0]       btn_sync_r;
    logic [2:0]       btn_db_r;
    logic [2:0]       btn_db_d_r;
    logic [2:0]       press_s;
    logic [CNT_W-1:0] db_cnt_r [3];

    assign btn_raw_s = {btn_run, btn_down, btn_up};

    // Two-stage synchronizer, per-button stability counter and debounced-level delay
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= 3'b000;
            btn_sync_r <= 3'b000;
            btn_db_r   <= 3'b000;
            btn_db_d_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
            btn_db_d_r <= btn_db_r;
            for (int i = 0; i < 3; i++) begin
                // Accept the new level only after DEBOUNCE_CYC consecutive differing samples.
                if (btn_sync_r[i] != btn_db_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        btn_db_r[i] <= btn_sync_r[i];
                        db_cnt_r[i] <= {CNT_W{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
                    end
                end else begin
                    db_cnt_r[i] <= {CNT_W{1'b0}};
                end
            end
        end
    end

    assign press_s = btn_db_r & ~btn_db_d_r;

    // ---------------- external sync ----------------
    logic ext_edge_s;

`ifdef CA_EXT_SYNC_EN
    logic ext_meta_r;
    logic ext_sync_r;
    logic ext_d_r;

    // Two-stage synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_meta_r <= 1'b0;
            ext_sync_r <= 1'b0;
            ext_d_r    <= 1'b0;
        end else begin
            ext_meta_r <= ext_sync;
            ext_sync_r <= ext_meta_r;
            ext_d_r    <= ext_sync_r;
        end
    end

    assign ext_edge_s = ext_sync_r & ~ext_d_r;
`else
    logic ext_unused_s;
    assign ext_unused_s = ext_sync;
    assign ext_edge_s   = 1'b0;
`endif

    // ---------------- sequencer ----------------
    state_t           state_r, state_nx;
    logic [ACC_W-1:0] acc_r, acc_nx;
    logic [ACC_W:0]   sum_s, look_s;
    logic [9:0]       chip_idx_r, idx_nx;
    logic [5:0]       prn_sel_r, prn_nx;
    logic [5:0]       pend_r, pend_nx;
    logic             chip_en_r, chip_en_nx;
    logic             epoch_r, epoch_nx;
    logic             gen_load_r, running_r;
    logic             led_tog_r, tog_nx;

    // Next-state, accumulator, chip index and PRN edit logic
    always_comb begin
        sum_s    = {1'b0, acc_r} + {1'b0, INC};
        state_nx = state_r;
        acc_nx   = acc_r;
        idx_nx   = chip_idx_r;

        if (press_s[0] && !press_s[1]) begin
            pend_nx = (pend_r == 6'd32) ? 6'd1 : pend_r + 6'd1;
        end else if (press_s[1] && !press_s[0]) begin
            pend_nx = (pend_r == 6'd1) ? 6'd32 : pend_r - 6'd1;
        end else begin
            pend_nx = pend_r;
        end

        case (state_r)
            ST_IDLE: begin
                acc_nx = {ACC_W{1'b0}};
                if (press_s[2]) begin
                    state_nx = ST_LOAD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LOAD: begin
                acc_nx   = {ACC_W{1'b0}};
                idx_nx   = 10'd0;
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                acc_nx = sum_s[ACC_W-1:0];
                if (chip_en_r) begin
                    idx_nx = (chip_idx_r == IDX_LAST) ? 10'd0 : chip_idx_r + 10'd1;
                end else begin
                    idx_nx = chip_idx_r;
                end
                // Run press wins over sync, sync wins over a pending-PRN reload.
                if (press_s[2]) begin
                    state_nx = ST_IDLE;
                end else if (ext_edge_s) begin
                    state_nx = ST_RESYNC;
                end else if (epoch_r && (pend_r != prn_sel_r)) begin
                    state_nx = ST_LOAD;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_RESYNC: begin
                state_nx = ST_LOAD;
            end
            default: begin
                acc_nx   = {ACC_W{1'b0}};
                state_nx = ST_IDLE;
            end
        endcase

        // chip_en/epoch are registered one cycle ahead: each is the carry that
        // the accumulator will produce in the cycle it is presented.
        look_s     = {1'b0, acc_nx} + {1'b0, INC};
        chip_en_nx = (state_nx == ST_RUN) && look_s[ACC_W];
        epoch_nx   = chip_en_nx && (idx_nx == IDX_LAST);
        tog_nx     = led_tog_r ^ epoch_nx;

        if ((state_nx == ST_IDLE) || (state_nx == ST_LOAD)) begin
            prn_nx = pend_nx;
        end else begin
            prn_nx = prn_sel_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            acc_r      <= {ACC_W{1'b0}};
            chip_idx_r <= 10'd0;
            prn_sel_r  <= 6'd1;
            pend_r     <= 6'd1;
            chip_en_r  <= 1'b0;
            epoch_r    <= 1'b0;
            gen_load_r <= 1'b0;
            running_r  <= 1'b0;
            led_tog_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            acc_r      <= acc_nx;
            chip_idx_r <= idx_nx;
            prn_sel_r  <= prn_nx;
            pend_r     <= pend_nx;
            chip_en_r  <= chip_en_nx;
            epoch_r    <= epoch_nx;
            gen_load_r <= (state_nx == ST_LOAD);
            running_r  <= (state_nx == ST_RUN);
            led_tog_r  <= tog_nx;
        end
    end

    assign prn_sel  = prn_sel_r;
    assign gen_load = gen_load_r;
    assign chip_en  = chip_en_r;
    assign chip_idx = chip_idx_r;
    assign epoch    = epoch_r;
    assign running  = running_r;
    assign led      = {led_tog_r, running_r, state_r, prn_sel_r};

endmodule

// File: tb/tb_ca_code_ctrl.sv
module tb_ca_code_ctrl;

    localparam int     DEB   = 4;
    localparam longint INC_M = (64'd1023000 * 64'd16777216 + 64'd6000000) / 64'd12000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_run = 1'b0, ext_sync = 1'b0;
    logic [5:0] prn_sel;
    logic       gen_load, chip_en, epoch, running;
    logic [9:0] chip_idx, led;

    ca_code_ctrl #(.DEBOUNCE_CYC(DEB)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .btn_run(btn_run), .ext_sync(ext_sync), .prn_sel(prn_sel),
        .gen_load(gen_load), .chip_en(chip_en), .chip_idx(chip_idx),
        .epoch(epoch), .running(running), .led(led)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // reference model state
    int j_m, prn_m, pend_m, idx_m, strobes_m, epochs_m, first_m;
    bit tog_m, load_next_m, load_seen;

    typedef struct { int kind; int exp_prn; } edit_vec_t;
    edit_vec_t tbl [7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap_prn(input int p, input int d);
        return ((p - 1 + d) % 32 + 32) % 32 + 1;
    endfunction

    // kind 0 = up, 1 = down, 2 = both together
    task automatic press_idle(input int kind);
        btn_up   = (kind == 0 || kind == 2);
        btn_down = (kind == 1 || kind == 2);
        repeat (10) tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (10) tick();
    endtask

    // One clock of RUN checked against the arithmetic chip-timing model:
    // j cycles after LOAD, strobes so far = floor((j-1)*INC / 2^24).
    task automatic step_check();
        longint     before_v, after_v;
        bit         en_v, ep_v;
        logic [9:0] led_v;
        tick();
        if (load_next_m) begin
            load_next_m = 1'b0;
            j_m = 0;
            prn_m = pend_m;
            idx_m = -1;
            load_seen = 1'b1;
            chk("load_gen_load", gen_load, 1);
            chk("load_chip_en", chip_en, 0);
            chk("load_idx", chip_idx, 0);
            chk("load_prn", prn_sel, prn_m);
            chk("load_state", led[7:6], 1);
        end else begin
            j_m++;
            before_v = (longint'(j_m - 1) * INC_M) >> 24;
            after_v  = (longint'(j_m) * INC_M) >> 24;
            en_v  = (after_v != before_v);
            idx_m = int'(before_v % 1023);
            ep_v  = en_v && (idx_m == 1022);
            if (ep_v) tog_m = ~tog_m;
            led_v = {tog_m, 1'b1, 2'd2, 6'(prn_m)};
            chk("run_chip_en", chip_en, en_v);
            chk("run_chip_idx", chip_idx, idx_m);
            chk("run_epoch", epoch, ep_v);
            chk("run_gen_load", gen_load, 0);
            chk("run_prn", prn_sel, prn_m);
            chk("run_led", led, led_v);
            if (en_v) begin
                strobes_m++;
                if (first_m == 0) first_m = j_m;
            end
            if (ep_v) begin
                epochs_m++;
                if (pend_m != prn_m) load_next_m = 1'b1;
            end
        end
    endtask

    initial begin
        int target, hold_idx;

        tbl[0] = '{1, 32};
        tbl[1] = '{0, 1};
        tbl[2] = '{0, 2};
        tbl[3] = '{2, 2};
        tbl[4] = '{1, 1};
        tbl[5] = '{1, 32};
        tbl[6] = '{0, 1};

        // ---- reset ----
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tog_m = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            chk("rst_prn", prn_sel, 1);
            chk("rst_led", led, 10'h001);
            chk("rst_chip_en", chip_en, 0);
        end

        // ---- table-driven PRN edits in IDLE ----
        for (int i = 0; i < 7; i++) begin
            press_idle(tbl[i].kind);
            chk("tbl_prn", prn_sel, tbl[i].exp_prn);
            chk("tbl_led", led, tbl[i].exp_prn);
        end
        pend_m = tbl[6].exp_prn;

        // ---- random PRN edits in IDLE ----
        for (int i = 0; i < 6; i++) begin
            int kind;
            kind = int'($urandom_range(0, 1));
            pend_m = wrap_prn(pend_m, (kind == 0) ? 1 : -1);
            press_idle(kind);
            chk("rnd_prn", prn_sel, pend_m);
        end
        prn_m = pend_m;

        // ---- run start: one gen_load, first strobe, one full epoch ----
        btn_run = 1'b1;
        load_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gen_load) begin
                load_seen = 1'b1;
                break;
            end
        end
        chk("start_load_seen", load_seen, 1);
        chk("start_load_prn", prn_sel, pend_m);
        chk("start_load_idx", chip_idx, 0);
        chk("start_load_state", led[7:6], 1);
        chk("start_load_chip_en", chip_en, 0);
        j_m = 0; strobes_m = 0; epochs_m = 0; first_m = 0; load_next_m = 1'b0;
        for (int k = 0; k < 13000; k++) begin
            if (j_m == 15) btn_run = 1'b0;
            step_check();
            if (strobes_m == 1023) break;
        end
        chk("start_strobes", strobes_m, 1023);
        chk("start_first_strobe", first_m, 12);
        chk("start_epochs", epochs_m, 1);
        chk("start_span_ok", (j_m >= 11988 && j_m <= 12012), 1);

        // ---- pending PRN applied at the next epoch ----
        target = int'($urandom_range(450, 550));
        for (int k = 0; k < 8000; k++) begin
            step_check();
            if (idx_m == target) break;
        end
        chk("pend_idx", chip_idx, target);
        for (int p = 0; p < 3; p++) begin
            btn_up = 1'b1;
            repeat (10) step_check();
            btn_up = 1'b0;
            repeat (10) step_check();
            pend_m = wrap_prn(pend_m, 1);
        end
        load_seen = 1'b0;
        for (int k = 0; k < 13000; k++) begin
            step_check();
            if (load_seen) break;
        end
        chk("pend_load_seen", load_seen, 1);
        repeat (20) step_check();

        // ---- external sync at chip 300 ----
        for (int k = 0; k < 5000; k++) begin
            step_check();
            if (idx_m == 300) break;
        end
        chk("ext_idx", chip_idx, 300);
        ext_sync = 1'b1;
`ifdef CA_EXT_SYNC_EN
        step_check();
        step_check();
        tick();
        chk("ext_resync_state", led[7:6], 3);
        chk("ext_resync_chip_en", chip_en, 0);
        chk("ext_resync_gen_load", gen_load, 0);
        chk("ext_resync_running", running, 0);
        tick();
        chk("ext_load_gen_load", gen_load, 1);
        chk("ext_load_idx", chip_idx, 0);
        chk("ext_load_state", led[7:6], 1);
        chk("ext_load_prn", prn_sel, prn_m);
        j_m = 0;
        ext_sync = 1'b0;
        repeat (30) step_check();
`else
        repeat (30) step_check();
        ext_sync = 1'b0;
        repeat (30) step_check();
`endif

        // ---- collision: run press and sync edge in the same cycle ----
        repeat (20) step_check();
        btn_run = 1'b1;
        repeat (4) step_check();
        ext_sync = 1'b1;
        repeat (2) step_check();
        hold_idx = int'(((longint'(j_m) * INC_M) >> 24) % 1023);
        tick();
        chk("col_state", led[7:6], 0);
        chk("col_running", running, 0);
        chk("col_gen_load", gen_load, 0);
        chk("col_chip_en", chip_en, 0);
        chk("col_idx", chip_idx, hold_idx);
        btn_run = 1'b0;
        ext_sync = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("col_hold_gen_load", gen_load, 0);
            chk("col_hold_running", running, 0);
            chk("col_hold_chip_en", chip_en, 0);
            chk("col_hold_idx", chip_idx, hold_idx);
        end

        // ---- reset mid-operation ----
        btn_run = 1'b1;
        load_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gen_load) begin
                load_seen = 1'b1;
                break;
            end
        end
        chk("mid_load_seen", load_seen, 1);
        btn_run = 1'b0;
        repeat (300) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_prn", prn_sel, 1);
        chk("mid_rst_led", led, 10'h001);
        chk("mid_rst_gen_load", gen_load, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_idx", chip_idx, 0);
        chk("mid_rst_chip_en", chip_en, 0);
        chk("mid_rst_epoch", epoch, 0);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("mid_idle_gen_load", gen_load, 0);
            chk("mid_idle_led", led, 10'h001);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
